// File: rtl/ysyx_22050710_csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op encoding,
// cause codes and mstatus bit positions.
package ysyx_22050710_csr_pkg;

    localparam logic [11:0] CsrMstatus  = 12'h300;
    localparam logic [11:0] CsrMtvec    = 12'h305;
    localparam logic [11:0] CsrMscratch = 12'h340;
    localparam logic [11:0] CsrMepc     = 12'h341;
    localparam logic [11:0] CsrMcause   = 12'h342;
    localparam logic [11:0] CsrMcycle   = 12'hB00;
    localparam logic [11:0] CsrMinstret = 12'hB02;

    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpWrite = 2'b01,
        OpSet   = 2'b10,
        OpClear = 2'b11
    } csr_op_e;

    localparam int unsigned CauseMEcall = 11;

    localparam int unsigned MstatusMie   = 3;
    localparam int unsigned MstatusMpie  = 7;
    localparam int unsigned MstatusMppLo = 11;
    localparam int unsigned MstatusMppHi = 12;

endpackage

// File: rtl/ysyx_22050710_csr_counter.sv
// Free-running XLEN counter with increment enable; a write in the same cycle
// overrides the increment.
module ysyx_22050710_csr_counter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_inc,
    input  logic            i_we,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_count
);

    logic [XLEN-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_we) begin
            count_d = i_wdata;
        end else if (i_inc) begin
            count_d = count_q + XLEN'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/ysyx_22050710_csr_file.sv
// Sparse machine-mode CSR file with Zicsr RMW ops, ecall/mret and a registered
// PC redirect. Define YSYX_22050710_CSR_COUNTERS_EN to add mcycle/minstret.
module ysyx_22050710_csr_file
    import ysyx_22050710_csr_pkg::*;
#(
    parameter int unsigned     XLEN          = 64,
    parameter int unsigned     ADDR_WIDTH    = 12,
    parameter logic [XLEN-1:0] MSTATUS_RESET = XLEN'(64'ha00001800)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_op,
    input  logic [XLEN-1:0]       i_wdata,
    input  logic                  i_ecall,
    input  logic                  i_mret,
    input  logic [XLEN-1:0]       i_epc,
    output logic [XLEN-1:0]       o_rdata,
    output logic                  o_illegal,
    output logic                  o_redirect,
    output logic [XLEN-1:0]       o_nextpc
);

    logic [XLEN-1:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, nextpc_q, nextpc_d;
    logic            redirect_q, redirect_d;

    logic sel_mstatus, sel_mtvec, sel_mscratch, sel_mepc, sel_mcause, cnt_hit, hit;
    logic trap_take, mret_take, csr_we;
    logic [XLEN-1:0] csr_new, cnt_rdata;
    csr_op_e         op;

    assign op           = csr_op_e'(i_op);
    assign sel_mstatus  = (i_addr == ADDR_WIDTH'(CsrMstatus));
    assign sel_mtvec    = (i_addr == ADDR_WIDTH'(CsrMtvec));
    assign sel_mscratch = (i_addr == ADDR_WIDTH'(CsrMscratch));
    assign sel_mepc     = (i_addr == ADDR_WIDTH'(CsrMepc));
    assign sel_mcause   = (i_addr == ADDR_WIDTH'(CsrMcause));
    assign hit = sel_mstatus | sel_mtvec | sel_mscratch | sel_mepc | sel_mcause | cnt_hit;

    assign trap_take = i_valid & i_ecall;
    assign mret_take = i_valid & ~i_ecall & i_mret;
    // RS/RC with a zero operand is a pure read and must not write.
    assign csr_we = i_valid & ~i_ecall & ~i_mret & hit & (op != OpNone) &
                    ((op == OpWrite) | (i_wdata != '0));

`ifdef YSYX_22050710_CSR_COUNTERS_EN
    logic            sel_mcycle, sel_minstret;
    logic [XLEN-1:0] mcycle, minstret;

    assign sel_mcycle   = (i_addr == ADDR_WIDTH'(CsrMcycle));
    assign sel_minstret = (i_addr == ADDR_WIDTH'(CsrMinstret));
    assign cnt_hit      = sel_mcycle | sel_minstret;
    assign cnt_rdata    = ({XLEN{sel_mcycle}} & mcycle) | ({XLEN{sel_minstret}} & minstret);

    ysyx_22050710_csr_counter #(.XLEN(XLEN)) u_mcycle (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (1'b1),
        .i_we    (csr_we & sel_mcycle),
        .i_wdata (csr_new),
        .o_count (mcycle)
    );

    ysyx_22050710_csr_counter #(.XLEN(XLEN)) u_minstret (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (i_valid),
        .i_we    (csr_we & sel_minstret),
        .i_wdata (csr_new),
        .o_count (minstret)
    );
`else
    assign cnt_hit   = 1'b0;
    assign cnt_rdata = '0;
`endif

    always_comb begin
        o_rdata = cnt_rdata;
        if (sel_mstatus)  o_rdata = mstatus_q;
        if (sel_mtvec)    o_rdata = mtvec_q;
        if (sel_mscratch) o_rdata = mscratch_q;
        if (sel_mepc)     o_rdata = mepc_q;
        if (sel_mcause)   o_rdata = mcause_q;
    end

    assign o_illegal = ~hit & (op != OpNone);

    always_comb begin
        unique case (op)
            OpWrite: csr_new = i_wdata;
            OpSet:   csr_new = o_rdata | i_wdata;
            OpClear: csr_new = o_rdata & ~i_wdata;
            default: csr_new = o_rdata;
        endcase
    end

    always_comb begin
        mstatus_d  = mstatus_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        nextpc_d   = nextpc_q;
        redirect_d = trap_take | mret_take;

        if (csr_we && sel_mstatus)  mstatus_d  = csr_new;
        if (csr_we && sel_mtvec)    mtvec_d    = csr_new;
        if (csr_we && sel_mscratch) mscratch_d = csr_new;
        if (csr_we && sel_mepc)     mepc_d     = csr_new;
        if (csr_we && sel_mcause)   mcause_d   = csr_new;

        if (trap_take) begin
            mepc_d                 = i_epc;
            mcause_d               = XLEN'(CauseMEcall);
            mstatus_d[MstatusMpie] = mstatus_q[MstatusMie];
            mstatus_d[MstatusMie]  = 1'b0;
            nextpc_d               = mtvec_q;
        end else if (mret_take) begin
            mstatus_d[MstatusMie]  = mstatus_q[MstatusMpie];
            mstatus_d[MstatusMpie] = 1'b1;
            nextpc_d               = mepc_q;
        end

        mtvec_d[1:0]                        = 2'b00;
        mepc_d[0]                           = 1'b0;
        mstatus_d[MstatusMppHi:MstatusMppLo] = 2'b11;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mstatus_q  <= MSTATUS_RESET;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            nextpc_q   <= '0;
            redirect_q <= 1'b0;
        end else begin
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            nextpc_q   <= nextpc_d;
            redirect_q <= redirect_d;
        end
    end

    assign o_redirect = redirect_q;
    assign o_nextpc   = nextpc_q;

endmodule

// File: tb/tb_ysyx_22050710_csr_file.sv
// Directed self-checking bench for ysyx_22050710_csr_file; counter checks follow
// YSYX_22050710_CSR_COUNTERS_EN.
module tb_ysyx_22050710_csr_file;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [11:0] i_addr = '0;
    logic [1:0]  i_op = '0;
    logic [63:0] i_wdata = '0;
    logic        i_ecall = 1'b0;
    logic        i_mret = 1'b0;
    logic [63:0] i_epc = '0;
    logic [63:0] o_rdata;
    logic        o_illegal;
    logic        o_redirect;
    logic [63:0] o_nextpc;

    int checks = 0;
    int errors = 0;

    always #10 i_clk = ~i_clk;

    ysyx_22050710_csr_file dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .i_addr     (i_addr),
        .i_op       (i_op),
        .i_wdata    (i_wdata),
        .i_ecall    (i_ecall),
        .i_mret     (i_mret),
        .i_epc      (i_epc),
        .o_rdata    (o_rdata),
        .o_illegal  (o_illegal),
        .o_redirect (o_redirect),
        .o_nextpc   (o_nextpc)
    );

    task automatic idle();
        i_valid = 1'b0;
        i_op    = 2'b00;
        i_wdata = '0;
        i_ecall = 1'b0;
        i_mret  = 1'b0;
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // One retiring CSR op; returns at the following negedge with inputs idle.
    task automatic csr_op(input logic [11:0] addr, input logic [1:0] op, input logic [63:0] d);
        i_valid = 1'b1;
        i_addr  = addr;
        i_op    = op;
        i_wdata = d;
        step();
        idle();
    endtask

    task automatic do_reset();
        idle();
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        do_reset();
        i_addr = 12'h300; #1;
        checks++;
        if (o_rdata !== 64'ha00001800) begin
            $display("FAIL reset_mstatus: got %h want %h", o_rdata, 64'ha00001800); errors++;
        end
        i_addr = 12'h305; #1;
        checks++;
        if (o_rdata !== 64'h0) begin
            $display("FAIL reset_mtvec: got %h want 0", o_rdata); errors++;
        end
        checks++;
        if (o_redirect !== 1'b0 || o_nextpc !== 64'h0) begin
            $display("FAIL reset_redirect: got %b/%h want 0/0", o_redirect, o_nextpc); errors++;
        end
        i_addr = 12'h123; i_op = 2'b01; #1;
        checks++;
        if (o_illegal !== 1'b1 || o_rdata !== 64'h0) begin
            $display("FAIL illegal_unimpl: got %b/%h want 1/0", o_illegal, o_rdata); errors++;
        end
        i_addr = 12'h300; #1;
        checks++;
        if (o_illegal !== 1'b0) begin
            $display("FAIL illegal_impl: got %b want 0", o_illegal); errors++;
        end
        idle();
    endtask

    task automatic test_write_masks();
        i_valid = 1'b1; i_addr = 12'h305; i_op = 2'b01; i_wdata = 64'h80000007; #1;
        checks++;
        if (o_rdata !== 64'h0) begin
            $display("FAIL mtvec_old_same_cycle: got %h want 0", o_rdata); errors++;
        end
        step(); idle(); #1;
        checks++;
        if (o_rdata !== 64'h80000004) begin
            $display("FAIL mtvec_mask: got %h want %h", o_rdata, 64'h80000004); errors++;
        end
        // Not retiring: must not write.
        i_op = 2'b01; i_wdata = 64'h1234; step(); idle(); #1;
        checks++;
        if (o_rdata !== 64'h80000004) begin
            $display("FAIL write_no_valid: got %h want %h", o_rdata, 64'h80000004); errors++;
        end
        csr_op(12'h341, 2'b01, 64'h80000011); i_addr = 12'h341; #1;
        checks++;
        if (o_rdata !== 64'h80000010) begin
            $display("FAIL mepc_mask: got %h want %h", o_rdata, 64'h80000010); errors++;
        end
        csr_op(12'h300, 2'b01, 64'h0); i_addr = 12'h300; #1;
        checks++;
        if (o_rdata !== 64'h1800) begin
            $display("FAIL mstatus_mpp: got %h want %h", o_rdata, 64'h1800); errors++;
        end
        csr_op(12'h7C0, 2'b01, 64'hFFFF); i_addr = 12'h7C0; #1;
        checks++;
        if (o_rdata !== 64'h0) begin
            $display("FAIL unimpl_write: got %h want 0", o_rdata); errors++;
        end
    endtask

    task automatic test_rmw();
        logic [63:0] exp [4] = '{64'hF0, 64'hFF, 64'hCF, 64'hCF};
        logic [1:0]  ops [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [63:0] dat [4] = '{64'hF0, 64'h0F, 64'h30, 64'h0};
        for (int k = 0; k < 4; k++) begin
            csr_op(12'h340, ops[k], dat[k]); i_addr = 12'h340; #1;
            checks++;
            if (o_rdata !== exp[k]) begin
                $display("FAIL rmw_%0d: got %h want %h", k, o_rdata, exp[k]); errors++;
            end
        end
    endtask

    task automatic test_ecall_mret();
        csr_op(12'h305, 2'b01, 64'h80000100);
        csr_op(12'h300, 2'b10, 64'h8);
        // Concurrent CSR op must be dropped in favour of the ecall.
        i_valid = 1'b1; i_ecall = 1'b1; i_mret = 1'b1; i_epc = 64'h80000010;
        i_addr = 12'h340; i_op = 2'b01; i_wdata = 64'hDEAD;
        step(); idle();
        checks++;
        if (o_redirect !== 1'b1 || o_nextpc !== 64'h80000100) begin
            $display("FAIL ecall_redirect: got %b/%h want 1/%h", o_redirect, o_nextpc,
                     64'h80000100); errors++;
        end
        i_addr = 12'h341; #1;
        checks++;
        if (o_rdata !== 64'h80000010) begin
            $display("FAIL ecall_mepc: got %h want %h", o_rdata, 64'h80000010); errors++;
        end
        i_addr = 12'h342; #1;
        checks++;
        if (o_rdata !== 64'd11) begin
            $display("FAIL ecall_mcause: got %h want 11", o_rdata); errors++;
        end
        i_addr = 12'h300; #1;
        checks++;
        if (o_rdata !== 64'h1880) begin
            $display("FAIL ecall_mstatus: got %h want %h", o_rdata, 64'h1880); errors++;
        end
        i_addr = 12'h340; #1;
        checks++;
        if (o_rdata !== 64'hCF) begin
            $display("FAIL ecall_drops_op: got %h want %h", o_rdata, 64'hCF); errors++;
        end
        step();
        checks++;
        if (o_redirect !== 1'b0 || o_nextpc !== 64'h80000100) begin
            $display("FAIL pulse_end: got %b/%h want 0/%h", o_redirect, o_nextpc,
                     64'h80000100); errors++;
        end
        i_valid = 1'b1; i_mret = 1'b1; step(); idle();
        i_addr = 12'h300; #1;
        checks++;
        if (o_redirect !== 1'b1 || o_nextpc !== 64'h80000010 || o_rdata !== 64'h1888) begin
            $display("FAIL mret: got %b/%h/%h want 1/%h/%h", o_redirect, o_nextpc, o_rdata,
                     64'h80000010, 64'h1888); errors++;
        end
    endtask

    task automatic test_back_to_back();
        csr_op(12'h305, 2'b01, 64'h80000200);
        i_valid = 1'b1; i_ecall = 1'b1; i_epc = 64'h80000040; step();
        checks++;
        if (o_redirect !== 1'b1 || o_nextpc !== 64'h80000200) begin
            $display("FAIL b2b_ecall: got %b/%h want 1/%h", o_redirect, o_nextpc,
                     64'h80000200); errors++;
        end
        i_ecall = 1'b0; i_mret = 1'b1; step(); idle();
        checks++;
        if (o_redirect !== 1'b1 || o_nextpc !== 64'h80000040) begin
            $display("FAIL b2b_mret: got %b/%h want 1/%h", o_redirect, o_nextpc,
                     64'h80000040); errors++;
        end
        step();
        checks++;
        if (o_redirect !== 1'b0) begin
            $display("FAIL b2b_end: got %b want 0", o_redirect); errors++;
        end
    endtask

    task automatic test_reset_mid();
        i_valid = 1'b1; i_ecall = 1'b1; i_epc = 64'h80000080; step(); idle();
        i_rst_n = 1'b0; i_addr = 12'h300; #1;
        checks++;
        if (o_redirect !== 1'b0 || o_nextpc !== 64'h0 || o_rdata !== 64'ha00001800) begin
            $display("FAIL reset_mid: got %b/%h/%h want 0/0/%h", o_redirect, o_nextpc, o_rdata,
                     64'ha00001800); errors++;
        end
        step();
        i_rst_n = 1'b1;
        i_valid = 1'b1; i_addr = 12'h340; i_op = 2'b01; i_wdata = 64'h55; step(); idle(); #1;
        checks++;
        if (o_rdata !== 64'h55) begin
            $display("FAIL post_reset_write: got %h want %h", o_rdata, 64'h55); errors++;
        end
    endtask

    task automatic test_counters();
`ifdef YSYX_22050710_CSR_COUNTERS_EN
        do_reset();
        for (int k = 0; k < 10; k++) begin
            i_valid = (k % 3 == 0);
            step();
        end
        idle();
        i_addr = 12'hB00; #1;
        checks++;
        if (o_rdata !== 64'd10) begin
            $display("FAIL mcycle: got %0d want 10", o_rdata); errors++;
        end
        i_addr = 12'hB02; #1;
        checks++;
        if (o_rdata !== 64'd4) begin
            $display("FAIL minstret: got %0d want 4", o_rdata); errors++;
        end
        csr_op(12'hB00, 2'b01, 64'd5); i_addr = 12'hB00; #1;
        checks++;
        if (o_rdata !== 64'd5) begin
            $display("FAIL mcycle_write: got %0d want 5", o_rdata); errors++;
        end
        csr_op(12'hB02, 2'b01, 64'd7); i_addr = 12'hB02; #1;
        checks++;
        if (o_rdata !== 64'd7) begin
            $display("FAIL minstret_write_wins: got %0d want 7", o_rdata); errors++;
        end
`else
        i_addr = 12'hB00; i_op = 2'b01; #1;
        checks++;
        if (o_illegal !== 1'b1 || o_rdata !== 64'h0) begin
            $display("FAIL mcycle_absent: got %b/%h want 1/0", o_illegal, o_rdata); errors++;
        end
        i_addr = 12'hB02; i_op = 2'b10; #1;
        checks++;
        if (o_illegal !== 1'b1 || o_rdata !== 64'h0) begin
            $display("FAIL minstret_absent: got %b/%h want 1/0", o_illegal, o_rdata); errors++;
        end
        idle();
`endif
    endtask

    initial begin
        test_reset();
        test_write_masks();
        test_rmw();
        test_ecall_mret();
        test_back_to_back();
        test_reset_mid();
        test_counters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_csr_file.md
# ysyx_22050710_csr_file

Machine-mode CSR file for the NPC core. It replaces the flat 4096-entry CSR array with a sparse, parametrised register set and adds Zicsr read-modify-write ops, `mret`, the `mstatus` interrupt-enable stack and optional hardware counters. It sits beside the GPR file in the execute/writeback stage. Its registered redirect drives the PC mux on trap entry and return.

## Interface
- `XLEN`, 64, CSR data width.
- `ADDR_WIDTH`, 12, CSR address width.
- `MSTATUS_RESET`, 64'ha00001800, `mstatus` reset value.
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_valid`  in  1  instruction in this stage is retiring this cycle.
- `i_addr`  in  ADDR_WIDTH  CSR address for read and write.
- `i_op`  in  2  operation: 00 none, 01 write (RW), 10 set (RS), 11 clear (RC).
- `i_wdata`  in  XLEN  operand: rs1 value or zero-extended uimm.
- `i_ecall`  in  1  environment call from M-mode.
- `i_mret`  in  1  return from trap.
- `i_epc`  in  XLEN  PC of the current instruction.
- `o_rdata`  out  XLEN  current value at `i_addr`, combinational; 0 if unimplemented.
- `o_illegal`  out  1  `i_addr` is unimplemented while `i_op != 00`, combinational.
- `o_redirect`  out  1  registered one-cycle pulse: take `o_nextpc`.
- `o_nextpc`  out  XLEN  registered redirect target.

## Operation
- Implemented registers:
  - `mstatus` 0x300
  - `mtvec` 0x305
  - `mscratch` 0x340
  - `mepc` 0x341
  - `mcause` 0x342
  - `mcycle` 0xB00 and `minstret` 0xB02, only under the configuration macro.
- Any other address reads 0 and ignores writes.
- The CSR op, trap and `mret` act only while `i_valid=1`. Priority: `i_ecall` > `i_mret` > CSR op. Lower-priority requests in the same cycle are dropped.
- CSR op new value:
  - RW: `i_wdata`.
  - RS: old | `i_wdata`.
  - RC: old & ~`i_wdata`.
  - RS/RC with `i_wdata=0` performs no write.
- Write masks:
  - `mtvec[1:0]` forced to 0 (direct mode only).
  - `mepc[0]` forced to 0.
  - `mstatus.MPP[12:11]` hardwired to 2'b11.
- `ecall`:
  - `mepc` <= `i_epc`.
  - `mcause` <= 11.
  - `MPIE[7]` <= `MIE[3]`.
  - `MIE` <= 0.
  - `o_nextpc` <= `mtvec` (value before this edge).
  - `o_redirect` <= 1.
- `mret`:
  - `MIE` <= `MPIE`.
  - `MPIE` <= 1.
  - `o_nextpc` <= `mepc`.
  - `o_redirect` <= 1.
- Reset values:
  - `mstatus` = `MSTATUS_RESET`.
  - All other CSRs = 0.
  - `o_redirect` = 0, `o_nextpc` = 0.

## Timing
- Reads are zero latency. A read in the same cycle as a write to the same address returns the old value. The new value is visible from the next cycle.
- Redirect latency is 1 cycle. `o_redirect` is high exactly one cycle, then returns to 0. `o_nextpc` holds its last value after the pulse.
- Back-to-back `ecall` then `mret` on consecutive cycles: two consecutive pulses, targets `mtvec` then `i_epc` of the `ecall`.
- Reset asserted mid-operation clears everything immediately, including a pending redirect pulse. The first edge after deassertion behaves as a normal cycle.

## Configuration
- `YSYX_22050710_CSR_COUNTERS_EN` defined:
  - `mcycle` increments every cycle out of reset.
  - `minstret` increments on each cycle with `i_valid=1`.
  - Both wrap from 2^XLEN−1 to 0.
  - A CSR write to a counter in the same cycle wins over its increment.
- Undefined: 0xB00 and 0xB02 are unimplemented; they read 0 and assert `o_illegal` on an op.

## Structure
- Package `ysyx_22050710_csr_pkg` holds:
  - CSR address constants.
  - The `i_op` encoding.
  - Cause codes (11 = M-ecall).
  - `mstatus` bit positions (MIE, MPIE, MPP).
- Sub-module `ysyx_22050710_csr_counter`: XLEN counter with increment enable and write-override port, instantiated once per counter under the macro.

## Test plan
- Reset, then read 0x300 → `o_rdata`=64'ha00001800. Read 0x305 → 0.
- RW 0x305 with `i_wdata`=0x80000007. Next cycle read → 0x80000004.
- RW 0x340 with 0xF0 → RS 0x340 with 0x0F → RC 0x340 with 0x30. Reads return 0xF0, then 0xFF, then 0xCF. RS with 0 leaves 0xCF.
- `mtvec`=0x80000100, `mstatus.MIE`=1; `ecall` with `i_epc`=0x80000010. Next cycle:
  - `o_redirect`=1, `o_nextpc`=0x80000100.
  - `mepc`=0x80000010, `mcause`=11.
  - MIE=0, MPIE=1.
- `mret` after the above → next cycle `o_redirect`=1, `o_nextpc`=0x80000010, MIE=1, MPIE=1.
- With the macro: after reset run 10 cycles with `i_valid` high on 4 of them → `mcycle`=10, `minstret`=4. RW 0xB00 with 5 → next cycle reads 5. Without the macro: op on 0xB00 → `o_illegal`=1.
